// File: rtl/sum_display_pkg.sv
// sum_display_pkg: shared state encoding and BCD digit-correction constants
package sum_display_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] DIGIT_ADJ_THRESH = 4'd5;
  localparam logic [BCD_W-1:0] DIGIT_ADJ = 4'd3;
endpackage

// File: rtl/sum_bcd_converter_if.sv
// sum_bcd_converter_if: operand input and BCD/hex result handshake bundle
interface sum_bcd_converter_if #(parameter int IN_W = 9, parameter int DIGITS = 3);
  logic in_valid;
  logic in_ready;
  logic [IN_W-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [4*DIGITS-1:0] bcd_out;
  logic [IN_W-1:0] hex_out;
  modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, bcd_out, hex_out);
  modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, bcd_out, hex_out);
endinterface

// File: rtl/bcd_add3_cell.sv
// bcd_add3_cell: double-dabble digit correction, adds 3 to any digit of 5 or more
module bcd_add3_cell
  import sum_display_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q
);
  assign q = d >= DIGIT_ADJ_THRESH ? d + DIGIT_ADJ : d;
endmodule

// File: rtl/sum_bcd_converter.sv
// sum_bcd_converter: iterative shift-add-3 binary to packed BCD converter with handshakes
module sum_bcd_converter
  import sum_display_pkg::*;
#(
  parameter int IN_W = 9,
  parameter int DIGITS = 3
) (
  input logic clk,
  input logic rst_n,
  sum_bcd_converter_if.slave bus
);
  localparam int CW = $clog2(IN_W + 1);
  localparam int BW = BCD_W * DIGITS;
  if (10 ** DIGITS <= 2 ** IN_W - 1) begin : g_chk
    $error("DIGITS too small for IN_W");
  end
  logic [1:0] state;
  logic [IN_W-1:0] opnd;
  logic [IN_W-1:0] hex_q;
  logic [BW-1:0] acc;
  logic [BW-1:0] adj;
  logic [BW-1:0] bcd_q;
  logic [CW-1:0] cnt;
  logic [BW+IN_W-1:0] shifted;
  for (genvar i = 0; i < DIGITS; i++) begin : g_cell
    bcd_add3_cell u_cell (.d(acc[i*BCD_W +: BCD_W]), .q(adj[i*BCD_W +: BCD_W]));
  end
  assign shifted = {adj, opnd} << 1;
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.bcd_out = bcd_q;
  assign bus.hex_out = hex_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      opnd <= '0;
      hex_q <= '0;
      acc <= '0;
      bcd_q <= '0;
      cnt <= '0;
    end else
      case (state)
        IDLE: if (bus.in_valid) begin
          state <= SHIFT;
          opnd <= bus.in_data;
          hex_q <= bus.in_data;
          acc <= '0;
          cnt <= CW'(IN_W);
        end
        SHIFT: begin
          {acc, opnd} <= shifted;
          cnt <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state <= DONE;
            bcd_q <= shifted[BW+IN_W-1 -: BW];
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_sum_bcd_converter.sv
// tb_sum_bcd_converter: directed table-driven check of the BCD converter
module tb_sum_bcd_converter;
  logic clk = 0;
  logic rst_n = 0;
  int compared = 0;
  int mismatched = 0;
  sum_bcd_converter_if #(.IN_W(9), .DIGITS(3)) bus ();
  sum_bcd_converter #(.IN_W(9), .DIGITS(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [8:0] din;
    logic [11:0] bcd;
    logic [8:0] hex;
    int hold;
  } vec_t;
  vec_t vecs[7];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic xfer(input logic [8:0] d, input logic [11:0] eb, input logic [8:0] eh, input int hold, input string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " idle"}, 32'(bus.in_ready), 1);
    bus.in_valid = 1;
    bus.in_data = d;
    bus.out_ready = hold == 0;
    @(negedge clk);
    bus.in_valid = 0;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      chk({nm, " busy"}, 32'(bus.in_ready), 0);
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 32'(n), 10);
    chk({nm, " bcd"}, 32'(bus.bcd_out), 32'(eb));
    chk({nm, " hex"}, 32'(bus.hex_out), 32'(eh));
    repeat (hold) begin
      @(negedge clk);
      chk({nm, " held valid"}, 32'(bus.out_valid), 1);
      chk({nm, " held ready"}, 32'(bus.in_ready), 0);
      chk({nm, " held bcd"}, 32'(bus.bcd_out), 32'(eb));
    end
    bus.out_ready = 1;
    @(negedge clk);
    chk({nm, " release valid"}, 32'(bus.out_valid), 0);
    chk({nm, " release ready"}, 32'(bus.in_ready), 1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
  initial begin
    int n;
    vecs[0] = '{9'd0, 12'h000, 9'h000, 0};
    vecs[1] = '{9'd511, 12'h511, 9'h1FF, 0};
    vecs[2] = '{9'd99, 12'h099, 9'h063, 0};
    vecs[3] = '{9'd100, 12'h100, 9'h064, 0};
    vecs[4] = '{9'd256, 12'h256, 9'h100, 5};
    vecs[5] = '{9'd255, 12'h255, 9'h0FF, 0};
    vecs[6] = '{9'd5, 12'h005, 9'h005, 2};
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 1;
    #12;
    chk("reset ready", 32'(bus.in_ready), 1);
    chk("reset valid", 32'(bus.out_valid), 0);
    chk("reset bcd", 32'(bus.bcd_out), 0);
    chk("reset hex", 32'(bus.hex_out), 0);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) xfer(vecs[i].din, vecs[i].bcd, vecs[i].hex, vecs[i].hold, $sformatf("vec%0d", i));
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_data = 9'd37;
    bus.out_ready = 1;
    @(negedge clk);
    bus.in_data = 9'd200;
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("hold latency", 32'(n), 10);
    chk("hold bcd", 32'(bus.bcd_out), 32'h037);
    chk("hold hex", 32'(bus.hex_out), 32'h025);
    @(negedge clk);
    chk("hold idle", 32'(bus.in_ready), 1);
    @(negedge clk);
    bus.in_valid = 0;
    chk("hold accept", 32'(bus.in_ready), 0);
    n = 1;
    while (!bus.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("second latency", 32'(n), 10);
    chk("second bcd", 32'(bus.bcd_out), 32'h200);
    chk("second hex", 32'(bus.hex_out), 32'h0C8);
    @(negedge clk);
    bus.in_valid = 1;
    bus.in_data = 9'd511;
    @(negedge clk);
    bus.in_valid = 0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("abort valid", 32'(bus.out_valid), 0);
    chk("abort ready", 32'(bus.in_ready), 1);
    chk("abort bcd", 32'(bus.bcd_out), 0);
    chk("abort hex", 32'(bus.hex_out), 0);
    @(negedge clk);
    rst_n = 1;
    xfer(9'd300, 12'h300, 9'h12C, 0, "after reset");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
